// File: rtl/mdu_divider.sv
// ============================================================================
// Module      : mdu_divider
// Description : Iterative restoring integer divider for the DIV/DIVU path.
//               It produces the quotient (LO) and remainder (HI) through a
//               Start/Busy/Done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_div_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // Magnitudes are plain unsigned values, so the most negative number maps onto itself.
  assign w_dvd_neg  = Signed & Dividend[WIDTH-1];
  assign w_dvs_neg  = Signed & Divisor[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? -Dividend : Dividend;
  assign w_dvs_mag  = w_dvs_neg ? -Divisor : Divisor;
  assign w_div_zero = (Divisor == '0);

  // The shifted remainder stays below twice the divisor, so the MSB of the difference is its sign.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};

  assign Busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_next = w_div_zero ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == c_last_cnt) begin
          w_next = S_FINISH;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dz      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_qneg <= w_dvd_neg ^ w_dvs_neg;
            r_rneg <= w_dvd_neg;
            r_dz   <= w_div_zero;
            r_dvsr <= w_dvs_mag;
            r_rem  <= '0;
            // A zero divisor keeps the raw dividend so it can be returned untouched.
            r_quo  <= w_div_zero ? Dividend : w_dvd_mag;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FINISH: begin
          Done <= 1'b1;
          if (r_dz) begin
            Quotient  <= '1;
            Remainder <= r_quo;
            DivZero   <= 1'b1;
          end else begin
            Quotient  <= r_qneg ? -r_quo : r_quo;
            Remainder <= r_rneg ? -r_rem : r_rem;
            DivZero   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_divider.sv
// ============================================================================
// Module      : tb_mdu_divider
// Description : Self-checking bench for mdu_divider against a behavioural
//               timing/arithmetic model plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_divider;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } res_t;

  logic             clk;
  logic             reset_n;
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;

  int n_pass  = 0;
  int n_total = 0;
  logic cmp_en = 1'b0;

  mdu_divider #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Start     (Start),
    .Signed    (Signed),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero),
    .Quotient  (Quotient),
    .Remainder (Remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: 64-bit signed math sidesteps the 0x80000000 / -1 overflow.
  function automatic res_t ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
    res_t   res;
    longint sa, sb, lq, lr;
    if (b == '0) begin
      res.q = '1; res.r = a; res.dz = 1'b1;
    end else if (!s) begin
      res.q = a / b; res.r = a % b; res.dz = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      res.q = lq[WIDTH-1:0]; res.r = lr[WIDTH-1:0]; res.dz = 1'b0;
    end
    return res;
  endfunction

  res_t c_res;
  assign c_res = ref_div(Dividend, Divisor, Signed);

  // Timing model: edges left until the finishing edge; 0 means idle.
  int   m_left;
  res_t m_pend;
  res_t m_out;
  logic m_done;
  logic m_busy;
  assign m_busy = (m_left != 0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= 0;
      m_pend <= '0;
      m_out  <= '0;
      m_done <= 1'b0;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      if (Start) begin
        m_pend <= c_res;
        m_left <= (Divisor == '0) ? 1 : WIDTH + 1;
      end
    end else if (m_left == 1) begin
      m_left <= 0;
      m_out  <= m_pend;
      m_done <= 1'b1;
    end else begin
      m_left <= m_left - 1;
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_busy", {31'd0, Busy}, {31'd0, m_busy});
      chk("cmp_done", {31'd0, Done}, {31'd0, m_done});
      chk("cmp_quotient", Quotient, m_out.q);
      chk("cmp_remainder", Remainder, m_out.r);
      chk("cmp_divzero", {31'd0, DivZero}, {31'd0, m_out.dz});
    end
  end

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    Start = 1'b1; Dividend = a; Divisor = b; Signed = s;
    @(posedge clk);
    #1;
    Start    = 1'b0;
    Dividend = $urandom;
    Divisor  = $urandom;
    Signed   = 1'($urandom);
  endtask

  task automatic wait_done(input string name, input int elat, input int elapsed);
    int  n;
    bit  seen;
    n = elapsed;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (Done) seen = 1;
    end
    chk(name, n, elat);
  endtask

  task automatic check_res(input string name, input logic [WIDTH-1:0] q,
                           input logic [WIDTH-1:0] r, input logic dz);
    chk({name, "_q"}, Quotient, q);
    chk({name, "_r"}, Remainder, r);
    chk({name, "_dz"}, {31'd0, DivZero}, {31'd0, dz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int dcount;
    reset_n = 1'b0; Start = 1'b0; Signed = 1'b0; Dividend = '0; Divisor = '0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_q", Quotient, 32'd0);
    chk("rst_r", Remainder, 32'd0);
    chk("rst_dz", {31'd0, DivZero}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    start_op(32'd100, 32'd7, 1'b0);
    chk("busy_after_start", {31'd0, Busy}, 32'd1);
    wait_done("lat_100_7", 33, 0);
    check_res("u100_7", 32'd14, 32'd2, 1'b0);
    chk("model_pin_q", m_out.q, 32'd14);
    chk("model_pin_r", m_out.r, 32'd2);

    start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("lat_m7_2", 33, 0);
    check_res("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

    start_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done("lat_7_m2", 33, 0);
    check_res("s_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0);
    chk("model_pin_s", m_out.q, 32'hFFFF_FFFD);

    start_op(32'd5, 32'd0, 1'b0);
    wait_done("lat_dz_u", 1, 0);
    check_res("dz_u", 32'hFFFF_FFFF, 32'd5, 1'b1);

    start_op(32'd5, 32'd0, 1'b1);
    wait_done("lat_dz_s", 1, 0);
    check_res("dz_s", 32'hFFFF_FFFF, 32'd5, 1'b1);

    start_op(32'd9, 32'd3, 1'b0);
    wait_done("lat_9_3", 33, 0);
    check_res("u9_3", 32'd3, 32'd0, 1'b0);

    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("lat_ovf", 33, 0);
    check_res("s_ovf", 32'h8000_0000, 32'd0, 1'b0);
    chk("model_pin_ovf", m_out.q, 32'h8000_0000);

    start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done("lat_max_1", 33, 0);
    check_res("u_max_1", 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Start pulse with other operands while busy must be ignored.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    Start = 1'b1; Dividend = 32'd8; Divisor = 32'd2; Signed = 1'b0;
    @(posedge clk);
    #1 Start = 1'b0;
    wait_done("lat_ignore", 33, 10);
    check_res("ignore", 32'd14, 32'd2, 1'b0);

    // New request issued in the Done cycle.
    start_op(32'd50, 32'd6, 1'b0);
    chk("done_drops", {31'd0, Done}, 32'd0);
    chk("hold_q", Quotient, 32'd14);
    wait_done("lat_50_6", 33, 0);
    check_res("u50_6", 32'd8, 32'd2, 1'b0);

    // Asynchronous reset in the middle of a run.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (15) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_done", {31'd0, Done}, 32'd0);
    chk("abort_q", Quotient, 32'd0);
    chk("abort_r", Remainder, 32'd0);
    chk("abort_dz", {31'd0, DivZero}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (Done) dcount++;
    end
    chk("no_done_after_abort", dcount, 32'd0);

    start_op(32'd100, 32'd7, 1'b0);
    wait_done("lat_after_abort", 33, 0);
    check_res("after_abort", 32'd14, 32'd2, 1'b0);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
